// File: rtl/bb_master_port_p_if.sv
// Bus-side signal bundle of the bit-serial master port: arbitration,
// address acknowledge, split, and the serial write/read lanes together
// with their per-bit handshakes.
interface bb_master_port_p_if;
  logic breq;
  logic bgrant;
  logic split;
  logic ack;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
  logic master_ready;

  modport master (
    output breq, mode, wr_bus, master_valid, master_ready,
    input  bgrant, split, ack, slave_ready, rd_bus, slave_valid
  );

  modport slave (
    input  breq, mode, wr_bus, master_valid, master_ready,
    output bgrant, split, ack, slave_ready, rd_bus, slave_valid
  );
endinterface

// File: rtl/bb_master_port_p.sv
// Bit-serial bus master port. Takes a burst request (address, mode, length)
// from the local side, arbitrates for the bus, shifts the address out LSB
// first, waits for the slave to accept it, then either shifts write words
// out (one word per slave_ready handshake) or collects read words bit by
// bit. A slave may split a read (or a pending address acceptance); the
// master then drops the bus and resumes where it stopped once re-granted.
// Every output is driven straight from a flop.
module bb_master_port_p #(
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  parameter  int TIMEOUT   = 255,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  m_addr,
  input  logic [DATA_W-1:0]  m_wr_data,
  input  logic               m_mode,
  input  logic [LEN_W-1:0]   m_len,
  input  logic               m_in_valid,
  output logic               m_in_ready,
  output logic [DATA_W-1:0]  m_rd_data,
  output logic               m_out_valid,
  output logic               m_wr_next,
  output logic               m_done,
  output logic               m_err,
  bb_master_port_p_if.master bus
);

  // One shared cycle counter covers address bits, write bits and the ack
  // wait; it must reach the largest of the three terminal values.
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_A   = (ADDR_W > DATA_W) ? ADDR_W - 1 : DATA_W - 1;
  localparam int CNT_MAX = (CNT_A > TO_LAST) ? CNT_A : TO_LAST;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  // Read bit position survives a split, so it has its own counter.
  localparam int RCNT_W  = (DATA_W < 2) ? 1 : $clog2(DATA_W);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_REQ      = 4'd1,
    ST_ADDR     = 4'd2,
    ST_WAIT_ACK = 4'd3,
    ST_WWAIT    = 4'd4,
    ST_WDATA    = 4'd5,
    ST_RDATA    = 4'd6,
    ST_SPLIT    = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  state_t state_r, state_n;

  logic [ADDR_W-1:0] addr_r,    addr_n;
  logic [DATA_W-1:0] data_r,    data_n;
  logic              mode_r,    mode_n;
  logic [LEN_W-1:0]  words_r,   words_n;
  logic [CNT_W-1:0]  cnt_r,     cnt_n;
  logic [RCNT_W-1:0] rd_cnt_r,  rd_cnt_n;
  logic [DATA_W-1:0] rd_sh_r,   rd_sh_n;
  logic              from_ack_r, from_ack_n;
  logic [DATA_W-1:0] rd_data_r, rd_data_n;
  logic              wr_bus_r,  wr_bus_n;
  logic              mvalid_r,  mvalid_n;
  logic              mready_r,  mready_n;
  logic              breq_r,    breq_n;
  logic              in_ready_r, in_ready_n;
  logic              out_valid_r, out_valid_n;
  logic              wr_next_r, wr_next_n;
  logic              done_r,    done_n;
  logic              err_r,     err_n;
  logic [DATA_W-1:0] cur_data_s;
  logic [DATA_W-1:0] rd_word_s;

  // Zero-length requests move one word; oversize requests are cut to the
  // largest burst the port supports.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == LEN_W'(0)) begin
      res = LEN_W'(1);
    end else if (len > LEN_W'(MAX_BURST)) begin
      res = LEN_W'(MAX_BURST);
    end else begin
      res = len;
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and next values of every datapath/output register.
  always_comb begin
    state_n     = state_r;
    addr_n      = addr_r;
    data_n      = data_r;
    mode_n      = mode_r;
    words_n     = words_r;
    cnt_n       = cnt_r;
    rd_cnt_n    = rd_cnt_r;
    rd_sh_n     = rd_sh_r;
    from_ack_n  = from_ack_r;
    rd_data_n   = rd_data_r;
    wr_bus_n    = 1'b0;
    mvalid_n    = 1'b0;
    out_valid_n = 1'b0;
    wr_next_n   = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    // The word requested by the m_wr_next pulse is on m_wr_data during the
    // pulse cycle itself, so it must be usable before it reaches data_r.
    cur_data_s  = wr_next_r ? m_wr_data : data_r;
    rd_word_s   = {bus.rd_bus, rd_sh_r[DATA_W-1:1]};

    case (state_r)
      ST_IDLE: begin
        if (m_in_valid) begin
          addr_n   = m_addr;
          data_n   = m_wr_data;
          mode_n   = m_mode;
          words_n  = clamp_len(m_len);
          cnt_n    = CNT_W'(0);
          rd_cnt_n = RCNT_W'(0);
          state_n  = ST_REQ;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.bgrant) begin
          wr_bus_n = addr_r[0];
          mvalid_n = 1'b1;
          addr_n   = {1'b0, addr_r[ADDR_W-1:1]};
          cnt_n    = CNT_W'(0);
          state_n  = ST_ADDR;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_ADDR: begin
        // The shift register already holds the next bit in position 0.
        if (cnt_r == CNT_W'(ADDR_W - 1)) begin
          cnt_n   = CNT_W'(0);
          state_n = ST_WAIT_ACK;
        end else begin
          cnt_n    = cnt_r + CNT_W'(1);
          wr_bus_n = addr_r[0];
          mvalid_n = 1'b1;
          addr_n   = {1'b0, addr_r[ADDR_W-1:1]};
        end
      end
      ST_WAIT_ACK: begin
        // ack outranks split; a split still high is taken a cycle later.
        if (bus.ack) begin
          cnt_n   = CNT_W'(0);
          state_n = mode_r ? ST_WWAIT : ST_RDATA;
        end else if (bus.split) begin
          from_ack_n = 1'b1;
          state_n    = ST_SPLIT;
        end else if (cnt_r == CNT_W'(TO_LAST)) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_WWAIT: begin
        data_n = cur_data_s;
        if (bus.slave_ready) begin
          wr_bus_n = cur_data_s[0];
          mvalid_n = 1'b1;
          data_n   = {1'b0, cur_data_s[DATA_W-1:1]};
          cnt_n    = CNT_W'(0);
          state_n  = ST_WDATA;
        end else begin
          state_n = ST_WWAIT;
        end
      end
      ST_WDATA: begin
        if (cnt_r == CNT_W'(DATA_W - 1)) begin
          words_n = words_r - LEN_W'(1);
          if (words_r > LEN_W'(1)) begin
            wr_next_n = 1'b1;
            state_n   = ST_WWAIT;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          cnt_n    = cnt_r + CNT_W'(1);
          wr_bus_n = data_r[0];
          mvalid_n = 1'b1;
          data_n   = {1'b0, data_r[DATA_W-1:1]};
        end
      end
      ST_RDATA: begin
        // A split takes precedence; the slave must not present a bit then.
        if (bus.split) begin
          from_ack_n = 1'b0;
          state_n    = ST_SPLIT;
        end else if (bus.slave_valid) begin
          rd_sh_n = rd_word_s;
          if (rd_cnt_r == RCNT_W'(DATA_W - 1)) begin
            rd_data_n   = rd_word_s;
            out_valid_n = 1'b1;
            rd_cnt_n    = RCNT_W'(0);
            words_n     = words_r - LEN_W'(1);
            if (words_r > LEN_W'(1)) begin
              state_n = ST_RDATA;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
            rd_cnt_n = rd_cnt_r + RCNT_W'(1);
          end
        end else begin
          state_n = ST_RDATA;
        end
      end
      ST_SPLIT: begin
        // Re-request only after split drops, resume once granted again;
        // the read bit/word position is simply left untouched.
        if (!bus.split && breq_r && bus.bgrant) begin
          cnt_n   = CNT_W'(0);
          state_n = from_ack_r ? ST_WAIT_ACK : ST_RDATA;
        end else begin
          state_n = ST_SPLIT;
        end
      end
      ST_DONE: begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_REQ, ST_ADDR, ST_WAIT_ACK, ST_WWAIT, ST_WDATA, ST_RDATA: breq_n = 1'b1;
      ST_SPLIT: breq_n = ~bus.split;
      default:  breq_n = 1'b0;
    endcase

    mready_n   = (state_n == ST_RDATA);
    in_ready_n = (state_n == ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      mode_r      <= 1'b0;
      words_r     <= LEN_W'(0);
      cnt_r       <= CNT_W'(0);
      rd_cnt_r    <= RCNT_W'(0);
      rd_sh_r     <= {DATA_W{1'b0}};
      from_ack_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      wr_bus_r    <= 1'b0;
      mvalid_r    <= 1'b0;
      mready_r    <= 1'b0;
      breq_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      wr_next_r   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      addr_r      <= addr_n;
      data_r      <= data_n;
      mode_r      <= mode_n;
      words_r     <= words_n;
      cnt_r       <= cnt_n;
      rd_cnt_r    <= rd_cnt_n;
      rd_sh_r     <= rd_sh_n;
      from_ack_r  <= from_ack_n;
      rd_data_r   <= rd_data_n;
      wr_bus_r    <= wr_bus_n;
      mvalid_r    <= mvalid_n;
      mready_r    <= mready_n;
      breq_r      <= breq_n;
      in_ready_r  <= in_ready_n;
      out_valid_r <= out_valid_n;
      wr_next_r   <= wr_next_n;
      done_r      <= done_n;
      err_r       <= err_n;
    end
  end

  assign m_in_ready       = in_ready_r;
  assign m_rd_data        = rd_data_r;
  assign m_out_valid      = out_valid_r;
  assign m_wr_next        = wr_next_r;
  assign m_done           = done_r;
  assign m_err            = err_r;
  assign bus.breq         = breq_r;
  assign bus.mode         = mode_r;
  assign bus.wr_bus       = wr_bus_r;
  assign bus.master_valid = mvalid_r;
  assign bus.master_ready = mready_r;

endmodule
